// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel period, high-time and enable,
// with shadowed config that is applied only on a period boundary while running.
module clk_div_multi #(
   parameter int NCH      = 4,
   parameter int CW       = 25,
   parameter int DEF_DIV  = 20000000,
   parameter int DEF_HIGH = 10000000,
   localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [NCH-1:0] EN,
   input  logic           CFG_WE,
   input  logic [CHW-1:0] CFG_CH,
   input  logic [CW-1:0]  CFG_DIV,
   input  logic [CW-1:0]  CFG_HIGH,
   output logic           CFG_ACK,
   output logic [NCH-1:0] PEND,
   output logic [NCH-1:0] CLK_O,
   output logic [NCH-1:0] TICK
);

   logic [CW-1:0]  div_c;
   logic [CW-1:0]  high_c;
   logic [NCH-1:0] sel;
   logic           ack_q;
   logic           ack_d;

   // Clamp once at the write port so every channel stores legal values.
   always_comb begin
      div_c  = (CFG_DIV < CW'(2)) ? CW'(2) : CFG_DIV;
      high_c = (CFG_HIGH > div_c) ? div_c : CFG_HIGH;
      ack_d  = |sel;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
      end
   end

   assign CFG_ACK = ack_q;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [CW-1:0] cnt_q, cnt_d;
         logic [CW-1:0] div_q, div_d;
         logic [CW-1:0] high_q, high_d;
         logic [CW-1:0] sh_div_q, sh_div_d;
         logic [CW-1:0] sh_high_q, sh_high_d;
         logic          pend_q, pend_d;
         logic          run_q, run_d;
         logic          clk_o_q, clk_o_d;
         logic          tick_q, tick_d;
         logic          wrap;

         // Out-of-range channel numbers simply never match any select.
         assign sel[gi] = CFG_WE && (CFG_CH == CHW'(gi));

         always_comb begin
            div_d     = div_q;
            high_d    = high_q;
            sh_div_d  = sh_div_q;
            sh_high_d = sh_high_q;
            pend_d    = pend_q;
            run_d     = EN[gi];
            cnt_d     = '0;
            clk_o_d   = 1'b0;
            tick_d    = 1'b0;
            wrap      = run_q && EN[gi] && (cnt_q == div_q - CW'(1));

            if (!EN[gi]) begin
               if (pend_q) begin
                  div_d  = sh_div_q;
                  high_d = sh_high_q;
                  pend_d = 1'b0;
               end
               if (sel[gi]) begin
                  div_d  = div_c;
                  high_d = high_c;
               end
            end else begin
               // A write on the wrap cycle lands in the shadow after the old shadow moves out.
               if (wrap && pend_q) begin
                  div_d  = sh_div_q;
                  high_d = sh_high_q;
                  pend_d = 1'b0;
               end
               if (sel[gi]) begin
                  sh_div_d  = div_c;
                  sh_high_d = high_c;
                  pend_d    = 1'b1;
               end
            end

            if (EN[gi]) begin
               if (run_q && !wrap) begin
                  cnt_d = cnt_q + CW'(1);
               end
               tick_d  = wrap;
               clk_o_d = (cnt_d < high_d);
            end
         end

         always_ff @(posedge CLK) begin
            if (RST) begin
               cnt_q     <= '0;
               div_q     <= CW'(DEF_DIV);
               high_q    <= CW'(DEF_HIGH);
               sh_div_q  <= '0;
               sh_high_q <= '0;
               pend_q    <= 1'b0;
               run_q     <= 1'b0;
               clk_o_q   <= 1'b0;
               tick_q    <= 1'b0;
            end else begin
               cnt_q     <= cnt_d;
               div_q     <= div_d;
               high_q    <= high_d;
               sh_div_q  <= sh_div_d;
               sh_high_q <= sh_high_d;
               pend_q    <= pend_d;
               run_q     <= run_d;
               clk_o_q   <= clk_o_d;
               tick_q    <= tick_d;
            end
         end

         assign PEND[gi]  = pend_q;
         assign CLK_O[gi] = clk_o_q;
         assign TICK[gi]  = tick_q;
      end
   endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed and randomized checks of clk_div_multi against a period-position reference model.
module tb_clk_div_multi;

   localparam int NCH      = 3;
   localparam int CW       = 8;
   localparam int DEF_DIV  = 20;
   localparam int DEF_HIGH = 10;
   localparam int CHW      = 2;

   logic           CLK = 1'b0;
   logic           RST;
   logic [NCH-1:0] EN;
   logic           CFG_WE;
   logic [CHW-1:0] CFG_CH;
   logic [CW-1:0]  CFG_DIV;
   logic [CW-1:0]  CFG_HIGH;
   logic           CFG_ACK;
   logic [NCH-1:0] PEND;
   logic [NCH-1:0] CLK_O;
   logic [NCH-1:0] TICK;

   clk_div_multi #(
      .NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)
   ) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
      .CFG_DIV(CFG_DIV), .CFG_HIGH(CFG_HIGH), .CFG_ACK(CFG_ACK),
      .PEND(PEND), .CLK_O(CLK_O), .TICK(TICK)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   // Model: position of the visible output inside its period, plus stored/shadow config.
   int m_pos[NCH];
   bit m_on[NCH];
   int m_div[NCH];
   int m_high[NCH];
   int m_sdiv[NCH];
   int m_shigh[NCH];
   bit m_pend[NCH];
   logic [NCH-1:0] e_clk, e_tick, e_pend;
   logic e_ack;
   logic [NCH-1:0] en_v;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input logic [NCH-1:0] en, input bit we,
                             input int ch, input int d, input int h);
      int cd, chh;
      bit boundary, wr;
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_pos[i] = 0; m_on[i] = 0; m_div[i] = DEF_DIV; m_high[i] = DEF_HIGH;
            m_sdiv[i] = 0; m_shigh[i] = 0; m_pend[i] = 0;
         end
         e_ack = 0; e_clk = '0; e_tick = '0; e_pend = '0;
         return;
      end
      e_ack = we && (ch < NCH);
      cd  = (d < 2) ? 2 : d;
      chh = (h > cd) ? cd : h;
      for (int i = 0; i < NCH; i++) begin
         boundary = m_on[i] && en[i] && (m_pos[i] == m_div[i] - 1);
         wr = e_ack && (ch == i);
         if (!en[i]) begin
            if (m_pend[i]) begin m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0; end
            if (wr) begin m_div[i] = cd; m_high[i] = chh; end
            m_on[i] = 0; m_pos[i] = 0;
            e_clk[i] = 0; e_tick[i] = 0;
         end else begin
            if (boundary && m_pend[i]) begin
               m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
            end
            if (wr) begin m_sdiv[i] = cd; m_shigh[i] = chh; m_pend[i] = 1; end
            if (!m_on[i] || boundary) m_pos[i] = 0;
            else m_pos[i] = m_pos[i] + 1;
            m_on[i] = 1;
            e_tick[i] = boundary;
            e_clk[i] = m_pos[i] < ((m_high[i] < m_div[i]) ? m_high[i] : m_div[i]);
         end
         e_pend[i] = m_pend[i];
      end
   endtask

   task automatic step(input bit rst, input logic [NCH-1:0] en, input bit we,
                       input int ch, input int d, input int h);
      RST = rst; EN = en; CFG_WE = we;
      CFG_CH = CHW'(ch); CFG_DIV = CW'(d); CFG_HIGH = CW'(h);
      @(posedge CLK);
      model_edge(rst, en, we, ch, d, h);
      #1;
      check("clk_o", 32'(CLK_O), 32'(e_clk));
      check("tick", 32'(TICK), 32'(e_tick));
      check("pend", 32'(PEND), 32'(e_pend));
      check("ack", 32'(CFG_ACK), 32'(e_ack));
      $display("step t=%0t rst=%0d en=%b we=%0d ch=%0d div=%0d high=%0d -> clk_o=%b tick=%b pend=%b ack=%0d",
               $time, rst, en, we, ch, d, h, CLK_O, TICK, PEND, CFG_ACK);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, en_v, 0, 0, 0, 0);
   endtask

   initial begin
      int waited;
      RST = 1; EN = '0; CFG_WE = 0; CFG_CH = '0; CFG_DIV = '0; CFG_HIGH = '0;
      en_v = '0;

      // Reset state, then defaults free-running on all channels.
      step(1, en_v, 0, 0, 0, 0);
      step(1, en_v, 0, 0, 0, 0);
      en_v = '1;
      idle(70);

      // Channel 0 configured while disabled, then enabled.
      en_v[0] = 0;
      idle(2);
      step(0, en_v, 1, 0, 5, 2);
      idle(2);
      en_v[0] = 1;
      idle(16);

      // Channel 1: 8/4 pattern, then two writes inside one period.
      en_v[1] = 0;
      step(0, en_v, 1, 1, 8, 4);
      en_v[1] = 1;
      idle(10);
      waited = 0;
      while (m_pos[1] != 2 && waited < 50) begin idle(1); waited++; end
      check("wait_cnt2", 32'(m_pos[1]), 32'd2);
      step(0, en_v, 1, 1, 4, 1);
      step(0, en_v, 1, 1, 6, 3);
      idle(20);

      // Clamps on channel 2 and a write to a nonexistent channel.
      step(0, en_v, 1, 2, 0, 1);
      idle(45);
      step(0, en_v, 1, 2, 5, 9);
      idle(15);
      step(0, en_v, 1, 2, 7, 0);
      idle(15);
      step(0, en_v, 1, NCH, 3, 1);
      idle(5);

      // Drop EN[2] while a shadow is pending.
      step(0, en_v, 1, 2, 9, 4);
      idle(1);
      en_v[2] = 0;
      idle(3);
      en_v[2] = 1;
      idle(12);

      // Reset mid-period with a pending shadow.
      step(0, en_v, 1, 1, 3, 1);
      step(1, en_v, 0, 0, 0, 0);
      idle(45);

      // Randomized traffic.
      for (int k = 0; k < 2000; k++) begin
         bit we;
         int ch, d, h;
         for (int i = 0; i < NCH; i++)
            if ($urandom_range(0, 39) == 0) en_v[i] = ~en_v[i];
         we = ($urandom_range(0, 3) == 0);
         ch = $urandom_range(0, 3);
         d  = $urandom_range(0, 12);
         h  = $urandom_range(0, 14);
         step($urandom_range(0, 499) == 0, en_v, we, ch, d, h);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
